dadda_final_cpa_pipe: RTL and testbench
=======================================

// Module: dadda_final_cpa_pipe
// PURPOSE
// - Final carry-propagate stage of the 32x32 Dadda multiplier. Sits directly downstream of
//   the 64-bit half-adder row, consuming its sum vector S and carry vector C.
// - Adds S + C over STAGES pipeline stages of CHUNK bits each, LSB chunk first, and
//   delivers the 64-bit product P.
// - Valid/ready handshake on both sides. The pipeline stalls in place under back-pressure.
// PARAMETERS
// - WIDTH   64  operand and product width
// - STAGES  4   number of pipeline stages; WIDTH % STAGES must be 0
// - CHUNK   WIDTH/STAGES (16)  bits resolved per stage; localparam, not overridable
// PORTS
// - clk        in   1      single clock; all state changes on rising edge
// - rst        in   1      asynchronous, active-high reset
// - S_in       in   WIDTH  sum vector from HA row (S_in[63] is 0 by construction)
// - C_in       in   WIDTH  carry vector from HA row (C_in[0] is 0 by construction)
// - in_valid   in   1      S_in/C_in valid this cycle
// - in_ready   out  1      stage 0 can accept; transfer when in_valid & in_ready
// - P          out  WIDTH  product = (S_in + C_in) mod 2^WIDTH
// - cout       out  1      carry out of bit WIDTH-1; must be 0 for legal products
// - out_valid  out  1      P/cout valid
// - out_ready  in   1      consumer accepts; transfer when out_valid & out_ready
// BEHAVIOUR
// - Reset (async assert; deassert sync to clk): all stage valid bits 0, P=0, cout=0,
//   out_valid=0. in_ready=1 once reset is deasserted.
// - Stage k register (k=0..STAGES-1) holds: valid_k; result bits [CHUNK*(k+1)-1:0];
//   unresolved S/C bits above that; running carry_k.
// - Stage 0 adds chunk 0 of S_in+C_in with cin=0. Stage k adds chunk k with
//   cin=carry_{k-1}. Resolved lower bits and unresolved upper bits pass through unchanged.
// - Final stage register drives P, cout and out_valid directly. No combinational
//   input-to-output path.
// - Per-stage advance: adv_k = !valid_k | adv_{k+1}, where adv_STAGES = out_ready.
//   in_ready = adv_0.
// - Stage k loads when adv_k. valid_k <= valid_{k-1} (stage 0: in_valid).
//   The data register holds when !adv_k.
// - Latency: exactly STAGES cycles from input handshake to out_valid with out_ready
//   held high. Throughput is one result per cycle, no bubbles.
// - Back-pressure: out_ready=0 with out_valid=1 holds P/cout stable. Upstream stages keep
//   filling empty slots until full. With all STAGES valid, in_ready=0 in the same cycle.
// - Simultaneous full pipe and out_ready=1: accept and drain in the same cycle,
//   throughput is kept.
// - Arithmetic is modulo 2^WIDTH; cout reports the dropped carry and has no other effect.
// - Reset mid-operation: all in-flight results are discarded at once and no partial
//   output appears. The first post-reset result needs a new input handshake.
// - No data reset is needed on internal S/C/result registers except P. Valid bits gate
//   everything.
// STRUCTURE
// - Shared package mult_pkg: MULT_W=32, PROD_W=64, CPA_STAGES=4. The HA row and
//   compressor tree use the same constants.
// - One sub-module: cpa_chunk.
//   * Purely combinational CHUNK-bit adder: (a, b, cin) -> (sum, cout).
//   * Instantiated STAGES times in a generate loop.
// - Top module contains only the stage registers and advance logic.
// TESTING
// - Reset: assert rst mid-stream with 3 items in flight -> out_valid=0, P=0 at once;
//   after release, no output until a new input.
// - Single op, out_ready=1:
//   * S_in=64'h0000_0000_FFFF_FFFF, C_in=64'h0000_0000_0000_0002 ->
//     P=64'h0000_0001_0000_0001, cout=0, exactly 4 cycles after the handshake.
//   * This checks carry propagation across a chunk boundary.
// - Full ripple: S_in=64'h7FFF_FFFF_FFFF_FFFF, C_in=64'h0000_0000_0000_0002 ->
//   P=64'h8000_0000_0000_0001, cout=0 (carry crosses all 4 chunks).
// - Overflow flag: S_in=64'hFFFF_FFFF_FFFF_FFFF, C_in=64'h2 -> P=64'h1, cout=1.
// - Back-pressure:
//   * Stream 8 back-to-back ops; hold out_ready=0 for cycles 5..9.
//   * Expect in_ready=0 once 4 are held and P stable while stalled.
//   * Expect all 8 results in order, none lost or duplicated.
// - Random: 10k random legal pairs (S_in[63]=0, C_in[0]=0) with random in_valid and
//   out_ready -> each P equals the scoreboard S+C, in order.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared constants for the 32x32 Dadda multiplier (HA row, compressor tree, final CPA).
package mult_pkg;

  localparam int MULT_W     = 32;
  localparam int PROD_W     = 64;
  localparam int CPA_STAGES = 4;

  // Bit offset of stage k's slot in the flat pending-carry register.
  // Stage j keeps the C bits above its own chunk: width - (j+1)*chunk bits.
  function automatic int c_off(input int width, input int chunk, input int k);
    int off;
    off = 0;
    for (int j = 0; j < k; j++) off += width - (j + 1) * chunk;
    return off;
  endfunction

endpackage

// File: rtl/cpa_chunk.sv
// One chunk of the final carry-propagate adder: purely combinational a + b + cin.
module cpa_chunk #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/dadda_final_cpa_pipe.sv
// Final CPA of the Dadda multiplier: S + C resolved CHUNK bits per stage, LSB first,
// with a valid/ready handshake on both sides and in-place stalling.
module dadda_final_cpa_pipe
  import mult_pkg::*;
#(
  parameter int WIDTH  = PROD_W,
  parameter int STAGES = CPA_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] S_in,
  input  logic [WIDTH-1:0] C_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] P,
  output logic             cout,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CHUNK = WIDTH / STAGES;
  // Pending C bits only shrink stage by stage; the last stage keeps none.
  localparam int CW    = c_off(WIDTH, CHUNK, STAGES - 1);

  logic [STAGES-1:0]            vld_q;
  logic [STAGES:0]              vld_pipe;
  logic [STAGES:0]              adv;
  logic [STAGES-1:0]            ld;

  logic [STAGES-1:0][WIDTH-1:0] s_src, s_nxt;
  logic [STAGES-1:0]            cy_src, cy_nxt;
  logic [STAGES-2:0][WIDTH-1:0] s_q;
  logic [STAGES-2:0]            cy_q;
  logic [CW-1:0]                c_q, c_nxt, c_en;

  logic [WIDTH-1:0]             p_q;
  logic                         cout_q;

  // vld_pipe[0] is the upstream request, vld_pipe[k+1] is stage k
  assign vld_pipe = {vld_q, in_valid};

  // Advance chain from the output backwards; a stage loads data only when it takes a valid item
  always_comb begin
    adv         = '0;
    ld          = '0;
    adv[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv[k] = !vld_q[k] | adv[k+1];
      ld[k]  = adv[k] & vld_pipe[k];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int REM = WIDTH - (k + 1) * CHUNK;
    localparam int OFF = c_off(WIDTH, CHUNK, k);
    localparam logic [WIDTH-1:0] MASK = {{(WIDTH-CHUNK){1'b0}}, {CHUNK{1'b1}}} << (k * CHUNK);

    logic [CHUNK-1:0] b_k, sum_k;

    if (k == 0) begin : g_head
      assign s_src[k]  = S_in;
      assign cy_src[k] = 1'b0;
      assign b_k       = C_in[CHUNK-1:0];
      assign c_nxt[OFF +: REM] = C_in[WIDTH-1:CHUNK];
    end else begin : g_tail
      localparam int POFF = c_off(WIDTH, CHUNK, k - 1);
      assign s_src[k]  = s_q[k-1];
      assign cy_src[k] = cy_q[k-1];
      // previous slot holds C bits from chunk k upward, lowest first
      assign b_k       = c_q[POFF +: CHUNK];
      if (k < STAGES - 1) begin : g_fwd
        assign c_nxt[OFF +: REM] = c_q[POFF+CHUNK +: REM];
      end
    end

    if (k < STAGES - 1) begin : g_en
      assign c_en[OFF +: REM] = {REM{ld[k]}};
    end

    cpa_chunk #(.W(CHUNK)) u_chunk (
      .a    (s_src[k][k*CHUNK +: CHUNK]),
      .b    (b_k),
      .cin  (cy_src[k]),
      .sum  (sum_k),
      .cout (cy_nxt[k])
    );

    // resolved chunk replaces the S bits it consumed; everything else passes through
    assign s_nxt[k] = (s_src[k] & ~MASK) | ({{(WIDTH-CHUNK){1'b0}}, sum_k} << (k * CHUNK));
  end

  // Valid shift register; a stage only moves when its advance is granted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++)
        if (adv[k]) vld_q[k] <= vld_pipe[k];
    end
  end

  // Intermediate data registers; valid bits gate their meaning so no reset
  always_ff @(posedge clk) begin
    for (int k = 0; k < STAGES - 1; k++) begin
      if (ld[k]) begin
        s_q[k]  <= s_nxt[k];
        cy_q[k] <= cy_nxt[k];
      end
    end
    c_q <= (c_q & ~c_en) | (c_nxt & c_en);
  end

  // Output register: P and cout are cleared so nothing stale shows after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q    <= '0;
      cout_q <= 1'b0;
    end else if (ld[STAGES-1]) begin
      p_q    <= s_nxt[STAGES-1];
      cout_q <= cy_nxt[STAGES-1];
    end
  end

  assign P         = p_q;
  assign cout      = cout_q;
  assign out_valid = vld_pipe[STAGES];
  assign in_ready  = adv[0];

endmodule

// File: tb/tb_dadda_final_cpa_pipe.sv
module tb_dadda_final_cpa_pipe;

  localparam int W = 64;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] S_in, C_in, P;
  logic         in_valid, in_ready, cout, out_valid, out_ready;

  int errors = 0;
  int checks = 0;

  // scoreboard of expected {cout, P}, oldest first
  logic [W:0] exp_q[$];

  always #5 clk = ~clk;

  dadda_final_cpa_pipe #(.WIDTH(W), .STAGES(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .S_in      (S_in),
    .C_in      (C_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .P         (P),
    .cout      (cout),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  function automatic logic [W:0] ref_sum(input logic [W-1:0] s, input logic [W-1:0] c);
    return {1'b0, s} + {1'b0, c};
  endfunction

  function automatic logic [W-1:0] rand_s();
    logic [W-1:0] v;
    v = {$urandom, $urandom};
    if ($urandom_range(0, 7) == 0) v = '1;
    v[W-1] = 1'b0;
    return v;
  endfunction

  function automatic logic [W-1:0] rand_c();
    logic [W-1:0] v;
    v = {$urandom, $urandom};
    if ($urandom_range(0, 7) == 0) v = 64'h2;
    v[0] = 1'b0;
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; S_in = '0; C_in = '0;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (P !== '0) begin errors++; $display("FAIL reset_P: got %h want 0", P); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b want 0", cout); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_single_op(input string name, input logic [W-1:0] s, input logic [W-1:0] c,
                                input logic [W-1:0] p, input logic co);
    int n;
    S_in = s; C_in = c; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_in_ready: got %b want 1", name, in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (out_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    checks++; if (n != N) begin errors++; $display("FAIL %s_latency: got %0d cycles want %0d", name, n, N); end
    checks++;
    if ({cout, P} !== {co, p}) begin
      errors++; $display("FAIL %s_result: got cout=%b P=%h want cout=%b P=%h", name, cout, P, co, p);
    end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_drained: out_valid=%b want 0", name, out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] sv[8], cv[8];
    logic [W:0]   e;
    logic [W-1:0] prev_p;
    logic         prev_stall, saw_full;
    int sent, recvd, cyc;
    for (int i = 0; i < 8; i++) begin sv[i] = rand_s(); cv[i] = rand_c(); end
    sent = 0; recvd = 0; cyc = 0; prev_stall = 1'b0; saw_full = 1'b0; prev_p = '0;
    exp_q.delete();
    while (recvd < 8 && cyc < 60) begin
      out_ready = !(cyc >= 5 && cyc <= 9);
      in_valid  = (sent < 8);
      S_in = sv[sent % 8]; C_in = cv[sent % 8];
      #1;
      checks++;
      if (in_ready !== (out_ready || exp_q.size() < N)) begin
        errors++; $display("FAIL b2b_in_ready cyc%0d: got %b want %b", cyc, in_ready, (out_ready || exp_q.size() < N));
      end
      if (!in_ready) saw_full = 1'b1;
      if (prev_stall) begin
        checks++; if (P !== prev_p) begin errors++; $display("FAIL b2b_stall_hold cyc%0d: got %h want %h", cyc, P, prev_p); end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_spurious cyc%0d: got P=%h want nothing", cyc, P);
        end else begin
          e = exp_q.pop_front();
          if ({cout, P} !== e) begin errors++; $display("FAIL b2b_result cyc%0d: got %b_%h want %b_%h", cyc, cout, P, e[W], e[W-1:0]); end
        end
        recvd++;
      end
      if (in_valid && in_ready) begin exp_q.push_back(ref_sum(sv[sent], cv[sent])); sent++; end
      prev_stall = out_valid && !out_ready;
      prev_p = P;
      @(posedge clk); #1; cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (recvd != 8) begin errors++; $display("FAIL b2b_count: got %0d results want 8", recvd); end
    checks++; if (saw_full !== 1'b1) begin errors++; $display("FAIL b2b_full: in_ready never dropped, want a 0"); end
  endtask

  task automatic test_reset_midstream();
    int n;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      S_in = rand_s(); C_in = rand_c(); in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid: got %b want 0", out_valid); end
    checks++; if (P !== '0) begin errors++; $display("FAIL midreset_P: got %h want 0", P); end
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) n++;
    end
    checks++; if (n != 0) begin errors++; $display("FAIL midreset_ghost: got %0d valid cycles want 0", n); end
    test_single_op("post_reset", 64'h0000_1234_0000_FFFE, 64'h0000_0000_0001_0002,
                   64'h0000_1234_0002_0000, 1'b0);
  endtask

  task automatic test_random();
    logic [W-1:0] s, c;
    logic [W:0]   e;
    int sent, recvd, cyc, bad;
    sent = 0; recvd = 0; cyc = 0; bad = 0;
    exp_q.delete();
    s = rand_s(); c = rand_c();
    while ((sent < 10000 || exp_q.size() != 0) && cyc < 60000) begin
      in_valid  = (sent < 10000) && ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 3) != 0);
      S_in = s; C_in = c;
      #1;
      checks++;
      if (in_ready !== (out_ready || exp_q.size() < N)) begin
        errors++; $display("FAIL rand_in_ready cyc%0d: got %b want %b", cyc, in_ready, (out_ready || exp_q.size() < N));
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_spurious cyc%0d: got P=%h want nothing", cyc, P);
        end else begin
          e = exp_q.pop_front();
          if ({cout, P} !== e) begin
            errors++;
            if (bad < 10) $display("FAIL rand_result #%0d: got %b_%h want %b_%h", recvd, cout, P, e[W], e[W-1:0]);
            bad++;
          end
        end
        recvd++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_sum(s, c)); sent++;
        s = rand_s(); c = rand_c();
      end
      @(posedge clk); #1; cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (recvd != 10000) begin errors++; $display("FAIL rand_count: got %0d results want 10000", recvd); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; S_in = '0; C_in = '0;
    test_reset();
    test_single_op("chunk_carry", 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0002,
                   64'h0000_0001_0000_0001, 1'b0);
    test_single_op("full_ripple", 64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0002,
                   64'h8000_0000_0000_0001, 1'b0);
    test_single_op("overflow", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0002,
                   64'h0000_0000_0000_0001, 1'b1);
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
